// File: rtl/bcd_counter_ctrl.sv
// bcd_counter_ctrl: sequencer for a cascaded pair of 74LS161-style counters
// (units, tens) that together form a BCD counter from 00 up to
// TENS_MAX:UNITS_MAX. It handles run, pause and single-step modes, a BCD
// preset load, and detection of the wrap back to 00. The counters share CP
// with this block, so every control output is combinational and the
// counters respond on the same edge as the command that drives them.
module bcd_counter_ctrl #(
    parameter int unsigned UNITS_MAX = 9,
    parameter int unsigned TENS_MAX  = 5
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       tick_en,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    input  logic       preset_en,
    input  logic [7:0] preset_val,
    input  logic [3:0] u_Q,
    input  logic [3:0] t_Q,
    output logic       u_CRBar,
    output logic       t_CRBar,
    output logic       u_LDBar,
    output logic       t_LDBar,
    output logic       u_CTP,
    output logic       u_CTT,
    output logic       t_CTP,
    output logic       t_CTT,
    output logic [3:0] u_D,
    output logic [3:0] t_D,
    output logic       wrap,
    output logic       preset_err,
    output logic [1:0] state
);

    localparam logic [3:0] U_MAX = 4'(UNITS_MAX);
    localparam logic [3:0] T_MAX = 4'(TENS_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t state_q;
    state_t next_state;
    logic   wrap_next;
    logic   err_next;
    logic   advance;
    logic   carry;
    logic   preset_ok;

    // Both counters are cleared directly by the controller reset.
    assign u_CRBar = ~CR;
    assign t_CRBar = ~CR;
    assign state   = state_q;

    assign preset_ok = (preset_val[3:0] <= U_MAX) && (preset_val[7:4] <= T_MAX);

    // Next-state decode and the counter controls, in priority order:
    // CR, preset, stop, start, then step/tick.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the priority chain leaves one unassigned (no latches).
        next_state = state_q;
        wrap_next  = 1'b0;
        err_next   = 1'b0;
        advance    = 1'b0;
        carry      = 1'b0;
        u_LDBar    = 1'b1;
        t_LDBar    = 1'b1;
        u_CTP      = 1'b0;
        u_CTT      = 1'b0;
        t_CTP      = 1'b0;
        t_CTT      = 1'b0;
        u_D        = 4'd0;
        t_D        = 4'd0;

        // The unused encoding falls back to IDLE on the next edge.
        case (state_q)
            IDLE, RUN, PAUSE: next_state = state_q;
            default:          next_state = IDLE;
        endcase

        if (CR) begin
            next_state = IDLE;
        end else if (preset_en) begin
            // A preset pre-empts any advance in the same cycle and never
            // changes the mode.
            if (preset_ok) begin
                u_LDBar = 1'b0;
                t_LDBar = 1'b0;
                u_D     = preset_val[3:0];
                t_D     = preset_val[7:4];
            end else begin
                err_next = 1'b1;
            end
        end else if (stop) begin
            if (state_q == RUN) next_state = PAUSE;
        end else if (start) begin
            if (state_q != RUN) next_state = RUN;
        end else begin
            advance = (state_q == RUN) ? tick_en : step;
        end

        if (advance) begin
            // Using >= rather than == also pulls an out-of-range digit back to 0.
            if (u_Q >= U_MAX) begin
                u_LDBar = 1'b0;
                u_D     = 4'd0;
                carry   = 1'b1;
            end else begin
                u_CTP = 1'b1;
                u_CTT = 1'b1;
            end

            if (carry) begin
                if (t_Q >= T_MAX) begin
                    t_LDBar   = 1'b0;
                    t_D       = 4'd0;
                    wrap_next = 1'b1;
                end else begin
                    t_CTP = 1'b1;
                    t_CTT = 1'b1;
                end
            end
        end
    end

    // Mode register and the one-cycle wrap / preset-error pulses.
    always_ff @(posedge CP) begin
        // NOTE: registered state uses non-blocking assignments so every
        // flop samples the pre-edge values of its inputs.
        if (CR) begin
            state_q    <= IDLE;
            wrap       <= 1'b0;
            preset_err <= 1'b0;
        end else begin
            state_q    <= next_state;
            wrap       <= wrap_next;
            preset_err <= err_next;
        end
    end

endmodule
